// File: rtl/io_pkg.sv
// Shared constants and helpers for the board input-conditioning path.
package io_pkg;

  localparam int unsigned IO_N_SW               = 8;
  localparam int unsigned IO_N_BTN              = 5;
  localparam int unsigned IO_DEB_CYCLES_DEFAULT = 1000000;
  localparam int unsigned IO_CNT_W_DEFAULT      = 20;
  localparam int unsigned IO_GLITCH_W           = 16;

  // Add k to a glitch count, pinning at all-ones instead of wrapping.
  function automatic logic [IO_GLITCH_W-1:0] glitch_sat_add(
    input logic [IO_GLITCH_W-1:0] a,
    input logic [IO_GLITCH_W-1:0] k
  );
    logic [IO_GLITCH_W:0] sum;
    sum = {1'b0, a} + {1'b0, k};
    return sum[IO_GLITCH_W] ? {IO_GLITCH_W{1'b1}} : sum[IO_GLITCH_W-1:0];
  endfunction

endpackage

// File: rtl/io_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability counter, level and edge strobes.
// glitch_c port exists only with IO_DEBOUNCE_STATS_EN.
module debounce_ch
  import io_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = IO_DEB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W      = IO_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic res,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
`ifdef IO_DEBOUNCE_STATS_EN
  ,
  output logic glitch_c
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

`ifdef IO_DEBOUNCE_STATS_EN
  // A partial count abandoned because the input fell back to the accepted level.
  assign glitch_c = (s2 == db) && (cnt != '0);
`endif

  always_ff @(posedge clk) begin
    if (res) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      db   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        db   <= s2;
        cnt  <= '0;
        rise <= s2;
        fall <= ~s2;
      end
    end
  end

endmodule

// File: rtl/io_debounce.sv
// Debounced switch/button levels plus edge strobes for the interrupt controller.
// IO_DEBOUNCE_STATS_EN adds a saturating rejected-glitch counter with clear.
module io_debounce
  import io_pkg::*;
#(
  parameter int unsigned N_SW       = IO_N_SW,
  parameter int unsigned N_BTN      = IO_N_BTN,
  parameter int unsigned DEB_CYCLES = IO_DEB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W      = IO_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             res,
  input  logic [N_SW-1:0]  switch,
  input  logic [N_BTN-1:0] button,
  output logic [N_SW-1:0]  switch_db,
  output logic [N_BTN-1:0] button_db,
  output logic [N_SW-1:0]  switch_chg,
  output logic [N_BTN-1:0] button_rise,
  output logic [N_BTN-1:0] button_fall
`ifdef IO_DEBOUNCE_STATS_EN
  ,
  output logic [IO_GLITCH_W-1:0] glitch_cnt,
  input  logic                   glitch_clr
`endif
);

  localparam int unsigned N_CH = N_SW + N_BTN;

  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;

`ifdef IO_DEBOUNCE_STATS_EN
  logic [N_CH-1:0] glitch_vec;
`endif

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_ch #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk (clk),
      .res (res),
      .raw (switch[i]),
      .db  (switch_db[i]),
      .rise(sw_rise[i]),
      .fall(sw_fall[i])
`ifdef IO_DEBOUNCE_STATS_EN
      ,
      .glitch_c(glitch_vec[i])
`endif
    );
    // rise and fall come from flops and are mutually exclusive
    assign switch_chg[i] = sw_rise[i] | sw_fall[i];
  end

  for (genvar j = 0; j < N_BTN; j++) begin : g_btn
    debounce_ch #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk (clk),
      .res (res),
      .raw (button[j]),
      .db  (button_db[j]),
      .rise(button_rise[j]),
      .fall(button_fall[j])
`ifdef IO_DEBOUNCE_STATS_EN
      ,
      .glitch_c(glitch_vec[N_SW+j])
`endif
    );
  end

`ifdef IO_DEBOUNCE_STATS_EN
  // Clear wins over any glitches landing in the same cycle.
  always_ff @(posedge clk) begin
    if (res || glitch_clr) begin
      glitch_cnt <= '0;
    end else begin
      glitch_cnt <= glitch_sat_add(glitch_cnt, IO_GLITCH_W'($countones(glitch_vec)));
    end
  end
`endif

endmodule

// File: tb/tb_io_debounce.sv
// Bench for io_debounce with DEB_CYCLES=4: directed scenarios plus random pin activity,
// checked every cycle against a sample-window model. Stats checks need IO_DEBOUNCE_STATS_EN.
module tb_io_debounce;
  import io_pkg::*;

  localparam int unsigned D   = 4;
  localparam int unsigned NCH = IO_N_SW + IO_N_BTN;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic [7:0] switch = 8'h00;
  logic [4:0] button = 5'h00;
  logic [7:0] switch_db, switch_chg;
  logic [4:0] button_db, button_rise, button_fall;
`ifdef IO_DEBOUNCE_STATS_EN
  logic [15:0] glitch_cnt;
  logic        glitch_clr = 1'b0;
  int unsigned mglitch = 0;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  io_debounce #(
    .N_SW(8), .N_BTN(5), .DEB_CYCLES(D), .CNT_W(3)
  ) dut (
    .clk        (clk),
    .res        (res),
    .switch     (switch),
    .button     (button),
    .switch_db  (switch_db),
    .button_db  (button_db),
    .switch_chg (switch_chg),
    .button_rise(button_rise),
    .button_fall(button_fall)
`ifdef IO_DEBOUNCE_STATS_EN
    ,
    .glitch_cnt (glitch_cnt),
    .glitch_clr (glitch_clr)
`endif
  );

  // Model: a level is accepted once the last D synchronised samples all disagree with it;
  // a glitch is a synchronised sample returning to the level right after a disagreeing one.
  bit       p1[NCH], p2[NCH];
  bit [7:0] hist[NCH];
  bit       mdb[NCH], mrise[NCH], mfall[NCH];

  always @(posedge clk) begin
    logic [NCH-1:0] raw;
    int k;
    bit s;
    raw = {button, switch};
    k = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (res) begin
        p1[ch] = 1'b0; p2[ch] = 1'b0; hist[ch] = 8'h00;
        mdb[ch] = 1'b0; mrise[ch] = 1'b0; mfall[ch] = 1'b0;
      end else begin
        s = p2[ch];
        hist[ch] = {hist[ch][6:0], s};
        mrise[ch] = 1'b0;
        mfall[ch] = 1'b0;
        if (s == mdb[ch] && hist[ch][1] != mdb[ch]) k++;
        if (hist[ch][D-1:0] == (mdb[ch] ? D'(0) : {D{1'b1}})) begin
          mdb[ch]   = ~mdb[ch];
          mrise[ch] = mdb[ch];
          mfall[ch] = ~mdb[ch];
        end
        p2[ch] = p1[ch];
        p1[ch] = raw[ch];
      end
    end
`ifdef IO_DEBOUNCE_STATS_EN
    if (res || glitch_clr) mglitch = 0;
    else mglitch = (mglitch + k > 32'hFFFF) ? 32'hFFFF : mglitch + k;
`endif
  end

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] esdb, esch;
    logic [4:0] ebdb, ebr, ebf;
    if (chk_en) begin
      for (int i = 0; i < 8; i++) begin
        esdb[i] = mdb[i];
        esch[i] = mrise[i] | mfall[i];
      end
      for (int j = 0; j < 5; j++) begin
        ebdb[j] = mdb[8+j];
        ebr[j]  = mrise[8+j];
        ebf[j]  = mfall[8+j];
      end
      cmp("m_switch_db", 32'(switch_db), 32'(esdb));
      cmp("m_switch_chg", 32'(switch_chg), 32'(esch));
      cmp("m_button_db", 32'(button_db), 32'(ebdb));
      cmp("m_button_rise", 32'(button_rise), 32'(ebr));
      cmp("m_button_fall", 32'(button_fall), 32'(ebf));
`ifdef IO_DEBOUNCE_STATS_EN
      cmp("m_glitch_cnt", 32'(glitch_cnt), mglitch);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_out();
    return 32'({switch_db, button_db, switch_chg, button_rise, button_fall});
  endfunction

  initial begin
    tick(3);
    chk_en = 1'b1;
    res = 1'b0;

    // idle after reset
    for (int i = 0; i < 50; i++) begin
      tick(1);
      cmp("idle", all_out(), 32'h0);
    end

    // clean switch step: level and strobe exactly 6 cycles after the drive
    switch[3] = 1'b1;
    tick(5);
    cmp("sw3_pre", 32'(switch_db), 32'h00);
    tick(1);
    cmp("sw3_db", 32'(switch_db), 32'h08);
    cmp("sw3_chg", 32'(switch_chg), 32'h08);
    cmp("sw3_btn", 32'({button_db, button_rise, button_fall}), 32'h0);
    tick(1);
    cmp("sw3_chg_end", 32'(switch_chg), 32'h00);
    cmp("sw3_hold", 32'(switch_db), 32'h08);

    // 3-cycle button pulse is rejected as a glitch
    button[0] = 1'b1;
    tick(3);
    button[0] = 1'b0;
    tick(3);
`ifdef IO_DEBOUNCE_STATS_EN
    cmp("btn0_glitch", 32'(glitch_cnt), 32'd1);
`endif
    tick(5);
    cmp("btn0_db", 32'(button_db), 32'h00);

    // button press and release strobes
    button[4] = 1'b1;
    tick(6);
    cmp("btn4_rise", 32'(button_rise), 32'h10);
    cmp("btn4_db", 32'(button_db), 32'h10);
    tick(1);
    cmp("btn4_rise_end", 32'(button_rise), 32'h00);
    tick(13);
    button[4] = 1'b0;
    tick(6);
    cmp("btn4_fall", 32'(button_fall), 32'h10);
    cmp("btn4_db_low", 32'(button_db), 32'h00);
    tick(1);
    cmp("btn4_fall_end", 32'(button_fall), 32'h00);

    // all pins toggle together
    switch = ~switch;
    button = ~button;
    tick(6);
    cmp("all_sw_db", 32'(switch_db), 32'hF7);
    cmp("all_sw_chg", 32'(switch_chg), 32'hFF);
    cmp("all_btn_db", 32'(button_db), 32'h1F);
    cmp("all_btn_rise", 32'(button_rise), 32'h1F);
    cmp("all_btn_fall", 32'(button_fall), 32'h00);
    tick(10);

    // toggle again, reset mid-count discards it
    switch = ~switch;
    button = ~button;
    tick(3);
    res = 1'b1;
    tick(1);
    res = 1'b0;
    cmp("mid_reset", all_out(), 32'h0);
    // switch[3] still high at reset release gets accepted after the latency
    tick(5);
    cmp("rel_pre", 32'(switch_db), 32'h00);
    tick(1);
    cmp("rel_db", 32'(switch_db), 32'h08);
    cmp("rel_chg", 32'(switch_chg), 32'h08);
    tick(4);

`ifdef IO_DEBOUNCE_STATS_EN
    switch = 8'h00;
    tick(12);
    cmp("sat_start", 32'(glitch_cnt), 32'd0);
    for (int i = 0; i < 5041; i++) begin
      switch = 8'hFF; button = 5'h1F;
      tick(1);
      switch = 8'h00; button = 5'h00;
      tick(1);
    end
    switch[0] = 1'b1;
    tick(1);
    switch[0] = 1'b0;
    tick(5);
    cmp("sat_fffe", 32'(glitch_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      switch[1] = 1'b1;
      tick(1);
      switch[1] = 1'b0;
      tick(1);
    end
    tick(4);
    cmp("sat_ffff", 32'(glitch_cnt), 32'hFFFF);
    button[2] = 1'b1;
    tick(1);
    button[2] = 1'b0;
    tick(2);
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    cmp("clr_prio", 32'(glitch_cnt), 32'h0);
    tick(3);
    cmp("clr_hold", 32'(glitch_cnt), 32'h0);
`endif

    // random pin activity with occasional resets and clears
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 8; i++)
        if ($urandom_range(0, 7) == 0) switch[i] = ~switch[i];
      for (int j = 0; j < 5; j++)
        if ($urandom_range(0, 7) == 0) button[j] = ~button[j];
      res = ($urandom_range(0, 499) == 0);
`ifdef IO_DEBOUNCE_STATS_EN
      glitch_clr = ($urandom_range(0, 49) == 0);
`endif
      tick(1);
    end
    res = 1'b0;
`ifdef IO_DEBOUNCE_STATS_EN
    glitch_clr = 1'b0;
`endif
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
